// File: rtl/riscv_mem_pkg.sv
// Shared RV32I memory-access definitions: widths, funct3 encodings and
// the legality/alignment helpers used by the data-memory responder.
package riscv_mem_pkg;

    localparam int DATA_W = 32;
    localparam int ADDR_W = 9;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    function automatic logic is_aligned(input logic [2:0] funct3, input logic [1:0] addr_lo);
        case (funct3)
            F3_H, F3_HU: return ~addr_lo[0];
            F3_W:        return addr_lo == 2'b00;
            default:     return 1'b1;
        endcase
    endfunction

    // Unsigned variants only exist for loads; 011/110/111 are never valid.
    function automatic logic is_legal(input logic [2:0] funct3, input logic wr);
        case (funct3)
            F3_B, F3_H, F3_W: return 1'b1;
            F3_BU, F3_HU:     return ~wr;
            default:          return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/mem_load_align.sv
// Combinational load formatter: picks the addressed byte/half/word out of a
// 32-bit memory word and sign- or zero-extends it according to funct3.
module mem_load_align (
    input  logic [31:0] word,
    input  logic [1:0]  addr_lo,
    input  logic [2:0]  funct3,
    output logic [31:0] result
);
    import riscv_mem_pkg::*;

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        byte_sel = word[8*addr_lo +: 8];
        half_sel = addr_lo[1] ? word[31:16] : word[15:0];
        case (funct3)
            F3_B:    result = {{24{byte_sel[7]}}, byte_sel};
            F3_H:    result = {{16{half_sel[15]}}, half_sel};
            F3_BU:   result = {24'h0, byte_sel};
            F3_HU:   result = {16'h0, half_sel};
            default: result = word;
        endcase
    end

endmodule

// File: rtl/data_mem_responder.sv
// Data-memory responder for the core's MEM stage: byte-addressed RV32I
// loads/stores with one-cycle read latency and error reporting.
module data_mem_responder #(
    parameter int DATA_W    = riscv_mem_pkg::DATA_W,
    parameter int ADDR_W    = riscv_mem_pkg::ADDR_W,
    parameter int ERR_CNT_W = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 wr,
    input  logic                 rd,
    input  logic [ADDR_W-1:0]    addr,
    input  logic [2:0]           funct3,
    input  logic [DATA_W-1:0]    wr_data,
    output logic [DATA_W-1:0]    rd_data,
    output logic                 rd_valid,
    output logic                 err,
    output logic                 err_sticky,
    output logic [ERR_CNT_W-1:0] err_count
);
    import riscv_mem_pkg::*;

    // Handshake: no backpressure. Every request cycle is answered in the next
    // cycle by exactly one of rd_valid (accepted load) or err (rejected access),
    // each a single-cycle pulse; a store-only request raises neither.
    localparam int WORDS = 1 << (ADDR_W - 2);

    logic [DATA_W-1:0]    mem_q [WORDS];
    logic [ADDR_W-3:0]    word_idx;
    logic                 req, ok, do_wr, do_rd, reject;
    logic [3:0]           be;
    logic [DATA_W-1:0]    wdata_lanes;

    logic [DATA_W-1:0]    rd_word_d, rd_word_q;
    logic [1:0]           ld_off_d, ld_off_q;
    logic [2:0]           ld_f3_d, ld_f3_q;
    logic                 rd_valid_d, rd_valid_q;
    logic                 err_d, err_q;
    logic                 err_sticky_d, err_sticky_q;
    logic [ERR_CNT_W-1:0] err_count_d, err_count_q;

    always_comb begin
        word_idx = addr[ADDR_W-1:2];
        req      = rd | wr;
        ok       = is_legal(funct3, wr) & is_aligned(funct3, addr[1:0]);
        do_wr    = ~reset & req & ok & wr;
        do_rd    = ~reset & req & ok & rd;
        reject   = ~reset & req & ~ok;

        // Replicating the right-aligned data lets the byte enables pick the lane.
        case (funct3[1:0])
            2'b00: begin
                be          = 4'b0001 << addr[1:0];
                wdata_lanes = {4{wr_data[7:0]}};
            end
            2'b01: begin
                be          = addr[1] ? 4'b1100 : 4'b0011;
                wdata_lanes = {2{wr_data[15:0]}};
            end
            default: begin
                be          = 4'b1111;
                wdata_lanes = wr_data;
            end
        endcase

        rd_word_d = rd_word_q;
        ld_off_d  = ld_off_q;
        ld_f3_d   = ld_f3_q;
        if (do_rd) begin
            rd_word_d = mem_q[word_idx];
            ld_off_d  = addr[1:0];
            ld_f3_d   = funct3;
        end

        rd_valid_d   = do_rd;
        err_d        = reject;
        err_sticky_d = err_sticky_q | reject;
        err_count_d  = err_count_q;
        if (reject && !(&err_count_q)) begin
            err_count_d = err_count_q + ERR_CNT_W'(1);
        end
    end

    // Read captures the pre-write word, so rd+wr together is read-before-write.
    always_ff @(posedge clk) begin
        if (do_wr) begin
            for (int b = 0; b < 4; b++) begin
                if (be[b]) begin
                    mem_q[word_idx][8*b +: 8] <= wdata_lanes[8*b +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rd_word_q    <= '0;
            ld_off_q     <= 2'b00;
            ld_f3_q      <= F3_W;
            rd_valid_q   <= 1'b0;
            err_q        <= 1'b0;
            err_sticky_q <= 1'b0;
            err_count_q  <= '0;
        end else begin
            rd_word_q    <= rd_word_d;
            ld_off_q     <= ld_off_d;
            ld_f3_q      <= ld_f3_d;
            rd_valid_q   <= rd_valid_d;
            err_q        <= err_d;
            err_sticky_q <= err_sticky_d;
            err_count_q  <= err_count_d;
        end
    end

    mem_load_align u_load_align (
        .word    (rd_word_q),
        .addr_lo (ld_off_q),
        .funct3  (ld_f3_q),
        .result  (rd_data)
    );

    assign rd_valid   = rd_valid_q;
    assign err        = err_q;
    assign err_sticky = err_sticky_q;
    assign err_count  = err_count_q;

endmodule

// File: doc/data_mem_responder.md
Name: data_mem_responder

Overview:
- Data-memory responder on the far end of the core's MEM-stage interface (wr, rd, addr, wr_data, rd_data).
- Accepts byte-addressed load/store requests from the pipeline and applies RV32I size/sign rules from funct3.
- Returns load data with a fixed one-cycle latency, like a synchronous block RAM.
- Detects misaligned or illegal accesses, suppresses them and reports them through pulse, sticky and count outputs.

Parameters:
- DATA_W, 32, data word width; fixed at 32 for RV32I.
- ADDR_W, 9, byte-address width; matches the core's addr port.
- ERR_CNT_W, 8, width of the saturating error counter.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous active-high reset
- wr  in  1  store request this cycle
- rd  in  1  load request this cycle
- addr  in  ADDR_W  byte address
- funct3  in  3  access size/sign (RV32I load/store funct3)
- wr_data  in  DATA_W  store data, right-aligned (byte in [7:0], half in [15:0])
- rd_data  out  DATA_W  load result, extended to 32 bits
- rd_valid  out  1  pulses with rd_data one cycle after an accepted load
- err  out  1  one-cycle pulse for a rejected access
- err_sticky  out  1  set by any err; cleared only by reset
- err_count  out  ERR_CNT_W  saturating count of err pulses

Behaviour:
- Clock and reset: one clock, clk. reset is synchronous and active-high.
- Storage: 2^(ADDR_W-2) words of 32 bits, little-endian; word index addr[ADDR_W-1:2], byte lane addr[1:0]. Contents are not cleared by reset.
- Reset values: rd_data=0, rd_valid=0, err=0, err_sticky=0, err_count=0. While reset is high, requests are discarded: no write, no rd_valid, no err.
- funct3 decode:
  - 000 LB/SB, 001 LH/SH, 010 LW/SW, 100 LBU, 101 LHU.
  - 100/101 with wr → illegal. 011/110/111 → illegal for both directions.
- Alignment: half needs addr[0]=0; word needs addr[1:0]=00. A violation counts as misaligned.
- Store (wr=1, legal, aligned):
  - Write at the clk edge ending the request cycle, using byte enables.
  - SB writes lane addr[1:0] with wr_data[7:0]. SH writes lanes {addr[1],0} and {addr[1],1} with wr_data[15:0]. SW writes all four lanes.
  - Unenabled bytes are preserved.
- Load (rd=1, legal, aligned), issued in cycle N:
  - In cycle N+1: rd_valid=1 and rd_data = the selected lane(s), sign-extended (LB/LH) or zero-extended (LBU/LHU).
  - rd_data holds its value until the next accepted load.
- Rejected access (illegal or misaligned):
  - No storage change and no rd_valid.
  - err=1 in the cycle after the request; err_sticky←1; err_count increments, saturating at 2^ERR_CNT_W-1.
  - rd_data is unchanged.
- rd and wr together: the write is performed and the load returns the pre-write word (read-before-write). The pair is checked as one access and raises at most one err.
- Store in cycle N then load of the same address in cycle N+1: the load returns the new data.
- Back-to-back loads: one result per cycle, rd_valid held high, no bubbles.
- Neither rd nor wr: rd_valid=0, err=0, storage unchanged.
- Reset mid-operation: a load issued in cycle N with reset high in N+1 gives rd_valid=0 and rd_data=0 in N+2's view, i.e. the reset values win.
- Addresses always fall within the array; ADDR_W defines the full space, so there is no out-of-range case.

Decomposition:
- Package riscv_mem_pkg holds:
  - the funct3 constants F3_B, F3_H, F3_W, F3_BU, F3_HU;
  - the width constants DATA_W and ADDR_W;
  - a function is_aligned(funct3, addr[1:0]).
- Sub-module mem_load_align (combinational): takes a word, addr[1:0] and funct3, and produces the extended 32-bit result. It is instantiated once on the registered read path.
- Store byte-enable and lane-shift generation stays inline.

Test Plan:
- SW 0xDEADBEEF @0x010, then LW @0x010 next cycle → rd_valid=1 one cycle later, rd_data=0xDEADBEEF, err=0.
- SB 0x80 @0x013, then LB @0x013 → 0xFFFFFF80. LBU @0x013 → 0x00000080. LW @0x010 → 0x80ADBEEF.
- SH 0x1234 @0x022 after SW 0 @0x020 → LW @0x020 = 0x12340000. LH @0x022 = 0x00001234.
- LW @0x011, then SH @0x023 → each gives err pulse one cycle later; memory unchanged; err_sticky=1; err_count=2; no rd_valid.
- rd and wr together: SW 0x5 with LW @0x030 holding 0x9 → rd_data=0x9. Next LW @0x030 → 0x5.
- 300 misaligned accesses → err_count saturates at 255. Then pulse reset for 1 cycle → all outputs 0; LW @0x010 still returns 0x80ADBEEF.
